four_bit_adder: RTL and testbench

FOUR_BIT_ADDER -- requirements
Module: four_bit_adder

---
 rtl/adder_pkg.sv | 7 +
 rtl/full_adder.sv | 21 ++
 rtl/four_bit_adder.sv | 89 ++++++++
 tb/tb_four_bit_adder.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared constants for the registered ripple-carry adder.
//   WIDTH : operand and sum width (only 4 is supported)
package adder_pkg;

    localparam int unsigned WIDTH = 4;

endpackage : adder_pkg

// File: rtl/full_adder.sv
// One-bit full adder, purely combinational; one ripple-chain stage.
//   a, b : operand bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p_c;

    // Propagate term shared by sum and carry.
    assign p_c = a ^ b;
    assign s   = p_c ^ ci;
    assign co  = (a & b) | (ci & p_c);

endmodule : full_adder

// File: rtl/four_bit_adder.sv
// Registered 4-bit ripple-carry adder with carry-out, signed overflow and a
// one-cycle valid pulse per accepted operand set.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   A, B      : unsigned operands
//   Cin       : carry in (weight 1)
//   in_valid  : A/B/Cin are sampled at the next rising edge when high
//   z         : registered sum bits [WIDTH-1:0]
//   Cout      : registered carry out
//   ovf       : registered two's-complement overflow
//   out_valid : high for one cycle when z/Cout/ovf carry a new result
module four_bit_adder #(
    parameter int unsigned WIDTH = adder_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] z,
    output logic             Cout,
    output logic             ovf,
    output logic             out_valid
);

    import adder_pkg::*;

    logic [WIDTH:0]   carry_c;
    logic [WIDTH-1:0] sum_c;
    logic             ovf_c;

    logic [WIDTH-1:0] z_q,         z_d;
    logic             cout_q,      cout_d;
    logic             ovf_q,       ovf_d;
    logic             out_valid_q, out_valid_d;

    // Ripple-carry chain: stage i consumes carry_c[i], produces carry_c[i+1].
    assign carry_c[0] = Cin;

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_stage
        full_adder u_fa (
            .a  (A[i]),
            .b  (B[i]),
            .ci (carry_c[i]),
            .s  (sum_c[i]),
            .co (carry_c[i+1])
        );
    end

    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign ovf_c = carry_c[WIDTH-1] ^ carry_c[WIDTH];

    // Next-state: load only on a valid sample so idle-cycle inputs (even X)
    // never reach the result registers.
    always_comb begin
        z_d         = z_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            z_d         = sum_c;
            cout_d      = carry_c[WIDTH];
            ovf_d       = ovf_c;
            out_valid_d = 1'b1;
        end
    end

    // Output registers; async reset also drops any result pending release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q         <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            z_q         <= z_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign z         = z_q;
    assign Cout      = cout_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;

endmodule : four_bit_adder

// File: tb/tb_four_bit_adder.sv
// Directed bench for four_bit_adder: reset, directed vectors, full operand
// sweep, idle hold with X/random inputs, and mid-cycle reset.
module tb_four_bit_adder;

    logic       clk;
    logic       rst_n;
    logic [3:0] A;
    logic [3:0] B;
    logic       Cin;
    logic       in_valid;
    logic [3:0] z;
    logic       Cout;
    logic       ovf;
    logic       out_valid;

    int tests_run;
    int tests_failed;

    four_bit_adder #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .in_valid  (in_valid),
        .z         (z),
        .Cout      (Cout),
        .ovf       (ovf),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs packed as {out_valid, ovf, Cout, z}.
    function automatic logic [6:0] observed();
        return {out_valid, ovf, Cout, z};
    endfunction

    // Reference: exact 5-bit sum; overflow when operand signs agree and the
    // result sign differs.
    function automatic logic [6:0] model(input logic [3:0] a, input logic [3:0] b,
                                         input logic c);
        logic [4:0] s;
        logic       v;
        s = 5'(a) + 5'(b) + 5'(c);
        v = (a[3] == b[3]) && (s[3] != a[3]);
        return {1'b1, v, s[4], s[3:0]};
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed {vld,ovf,cout,z}=%b expected %b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic c,
                         input logic v);
        @(negedge clk);
        A        = a;
        B        = b;
        Cin      = c;
        in_valid = v;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        A        = '0;
        B        = '0;
        Cin      = 1'b0;
        in_valid = 1'b0;
        rst_n    = 1'b1;

        // Reset takes effect without a clock edge.
        #1 rst_n = 1'b0;
        #1 check("reset_async", observed(), 7'b0_0_0_0000);
        after_edge();
        check("reset_held", observed(), 7'b0_0_0_0000);
        @(negedge clk);
        rst_n = 1'b1;
        after_edge();
        check("idle_after_reset", observed(), 7'b0_0_0_0000);

        // Directed vectors.
        drive(4'b1100, 4'b1011, 1'b0, 1'b1);
        after_edge();
        check("c_plus_b", observed(), 7'b1_1_1_0111);

        drive(4'hF, 4'hF, 1'b1, 1'b1);
        after_edge();
        check("f_plus_f_plus_1", observed(), 7'b1_0_1_1111);

        drive(4'h0, 4'h0, 1'b0, 1'b1);
        after_edge();
        check("zero_sum", observed(), 7'b1_0_0_0000);

        drive(4'hF, 4'h0, 1'b1, 1'b1);
        after_edge();
        check("wrap_to_zero", observed(), 7'b1_0_1_0000);

        drive(4'h8, 4'h8, 1'b0, 1'b1);
        after_edge();
        check("neg_overflow", observed(), 7'b1_1_1_0000);

        drive(4'h7, 4'h1, 1'b0, 1'b1);
        after_edge();
        check("pos_overflow", observed(), 7'b1_1_0_1000);

        // Idle with random operands: result holds, out_valid drops.
        for (int i = 0; i < 3; i++) begin
            drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 1'b0);
            after_edge();
            check($sformatf("hold_rand_%0d", i), observed(), 7'b0_1_0_1000);
        end

        // Idle with X operands: nothing propagates.
        drive(4'bxxxx, 4'bxxxx, 1'bx, 1'b0);
        after_edge();
        check("hold_x_inputs", observed(), 7'b0_1_0_1000);

        // Exhaustive sweep, in_valid high every cycle.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    drive(4'(a), 4'(b), 1'(c), 1'b1);
                    after_edge();
                    check($sformatf("sweep_%0d_%0d_%0d", a, b, c), observed(),
                          model(4'(a), 4'(b), 1'(c)));
                end
            end
        end

        // Reset mid-cycle right after a sample: outputs clear immediately.
        drive(4'hF, 4'hF, 1'b1, 1'b1);
        after_edge();
        check("pre_reset_result", observed(), 7'b1_0_1_1111);
        #2 rst_n = 1'b0;
        #1 check("reset_midcycle", observed(), 7'b0_0_0_0000);

        // Valid operands offered during reset are not taken.
        @(negedge clk);
        A        = 4'hC;
        B        = 4'hB;
        Cin      = 1'b1;
        in_valid = 1'b1;
        after_edge();
        check("reset_ignores_valid", observed(), 7'b0_0_0_0000);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        after_edge();
        check("no_pulse_after_release", observed(), 7'b0_0_0_0000);

        // First valid edge after release is sampled.
        drive(4'h3, 4'h4, 1'b1, 1'b1);
        after_edge();
        check("first_after_release", observed(), 7'b1_1_0_1000);
        drive(4'h0, 4'h0, 1'b0, 1'b0);
        after_edge();
        check("single_pulse", observed(), 7'b0_1_0_1000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_four_bit_adder
